uart_rx_frame_ctrl: RTL and testbench

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

---
 rtl/uart_ctrl_pkg.sv | 19 +
 rtl/uart_rx_frame_ctrl_if.sv | 13 +
 rtl/uart_rx_frame_ctrl_fifo.sv | 58 +++++
 rtl/uart_rx_frame_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART receive framing controller: FSM state codes,
// error codes and the default start-of-frame marker.
package uart_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_LEN     = 2'd1;
    localparam state_t ST_PAYLOAD = 2'd2;
    localparam state_t ST_CSUM    = 2'd3;

    localparam logic [1:0] ERR_OVERFLOW = 2'b00;
    localparam logic [1:0] ERR_ZERO_LEN = 2'b01;
    localparam logic [1:0] ERR_CSUM     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Payload stream from the frame controller to its consumer (valid/ready, with a
// last-byte marker).
interface uart_rx_frame_ctrl_if;

    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_last, output out_valid, input  out_ready);
    modport slave  (input  out_data, input  out_last, input  out_valid, output out_ready);

endinterface

// File: rtl/uart_rx_frame_ctrl_fifo.sv
// Synchronous payload FIFO; a write on a full FIFO is accepted only when a pop
// frees an entry in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_rd;
    logic             do_wr;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + (AW+1)'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Parses SYNC/LEN/payload/checksum frames from a UART receiver, streams the payload
// through a FIFO and reports per-frame status.
module uart_rx_frame_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_done,
    input  logic [15:0]                 timeout_cycles,
    uart_rx_frame_ctrl_if.master        out_if,
    output logic                        frame_ok,
    output logic                        frame_err,
    output logic [1:0]                  err_code,
    output logic [7:0]                  frame_cnt
);

    state_t      state;
    logic        rx_done_q;
    logic        armed;
    logic [7:0]  remain;
    logic [7:0]  csum;
    logic        ovf;
    logic [15:0] idle_cnt;
    logic        byte_ev;
    logic        expire;
    logic        fifo_wr;
    logic        fifo_rd;
    logic        fifo_full;
    logic        fifo_empty;
    logic [8:0]  fifo_rdata;

    // armed stays low until rx_done is seen low, so a level held through reset is not a byte
    assign byte_ev = rx_done && !rx_done_q && armed;
    assign expire  = (timeout_cycles != 16'd0) && (state != ST_IDLE) &&
                     (({1'b0, idle_cnt} + 17'd1) == {1'b0, timeout_cycles});
    assign fifo_wr = byte_ev && (state == ST_PAYLOAD);
    assign fifo_rd = out_if.out_valid && out_if.out_ready;

    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = fifo_rdata[7:0];
    assign out_if.out_last  = fifo_rdata[8];

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data ({remain == 8'd1, rx_data}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_done_q <= 1'b0;
            armed     <= 1'b0;
        end else begin
            rx_done_q <= rx_done;
            armed     <= armed | ~rx_done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remain    <= '0;
            csum      <= '0;
            ovf       <= 1'b0;
            idle_cnt  <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_OVERFLOW;
            frame_cnt <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (byte_ev || state == ST_IDLE) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 16'd1;
            end
            // a byte arriving on the expiry cycle keeps the frame alive
            if (expire && !byte_ev) begin
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                state     <= ST_IDLE;
                ovf       <= 1'b0;
            end else if (byte_ev) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= ST_LEN;
                            ovf   <= 1'b0;
                        end
                    end
                    ST_LEN: begin
                        if (rx_data == 8'd0) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_ZERO_LEN;
                            state     <= ST_IDLE;
                        end else begin
                            remain <= rx_data;
                            csum   <= rx_data;
                            state  <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        csum   <= csum + rx_data;
                        remain <= remain - 8'd1;
                        if (fifo_full && !fifo_rd) begin
                            ovf <= 1'b1;
                        end
                        if (remain == 8'd1) begin
                            state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (ovf) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_OVERFLOW;
                        end else if (rx_data == csum) begin
                            frame_ok  <= 1'b1;
                            frame_cnt <= frame_cnt + 8'd1;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CSUM;
                        end
                        state <= ST_IDLE;
                        ovf   <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: frame-level reference model compared every cycle,
// directed frames with literal expectations, then randomized frames.
module tb_uart_rx_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic [15:0] timeout_cycles = 16'd0;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [7:0]  frame_cnt;
    int          ready_mode = 1;

    uart_rx_frame_ctrl_if out_if ();

    uart_rx_frame_ctrl #(.FIFO_DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_done        (rx_done),
        .timeout_cycles (timeout_cycles),
        .out_if         (out_if),
        .frame_ok       (frame_ok),
        .frame_err      (frame_err),
        .err_code       (err_code),
        .frame_cnt      (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: tracks the bytes of the current frame and decides at frame level.
    logic [8:0] mq[$];
    logic [7:0] frm[$];
    bit         in_frame = 1'b0;
    bit         ovf_m = 1'b0;
    bit         prev_done = 1'b1;
    int         idle = 0;
    int         cyc = 0;
    int         last_ev_cyc = 0;
    int         n_m;
    int         len_m;
    logic [7:0] sum_m;
    bit         exp_ok = 1'b0;
    bit         exp_err = 1'b0;
    logic [1:0] exp_code = 2'b00;
    logic [7:0] exp_cnt = 8'h00;

    task automatic model_err(input logic [1:0] code);
        exp_err  = 1'b1;
        exp_code = code;
        in_frame = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            frm.delete();
            in_frame = 1'b0;
            ovf_m = 1'b0;
            prev_done = 1'b1;
            idle = 0;
            exp_ok = 1'b0;
            exp_err = 1'b0;
            exp_code = 2'b00;
            exp_cnt = 8'h00;
        end else begin
            cyc++;
            exp_ok  = 1'b0;
            exp_err = 1'b0;
            if (mq.size() != 0 && out_if.out_ready) void'(mq.pop_front());
            if (rx_done && !prev_done) begin
                last_ev_cyc = cyc;
                idle = 0;
                if (!in_frame) begin
                    if (rx_data == 8'hA5) begin
                        in_frame = 1'b1;
                        frm.delete();
                        ovf_m = 1'b0;
                    end
                end else begin
                    frm.push_back(rx_data);
                    n_m = frm.size();
                    len_m = int'(frm[0]);
                    if (len_m == 0) begin
                        model_err(2'b01);
                    end else if (n_m <= len_m + 1) begin
                        if (n_m >= 2) begin
                            if (mq.size() < 16) mq.push_back({(n_m == len_m + 1), rx_data});
                            else ovf_m = 1'b1;
                        end
                    end else begin
                        sum_m = 8'h00;
                        for (int i = 0; i <= len_m; i++) sum_m = sum_m + frm[i];
                        if (ovf_m) model_err(2'b00);
                        else if (rx_data != sum_m) model_err(2'b10);
                        else begin
                            exp_ok = 1'b1;
                            exp_cnt = exp_cnt + 8'd1;
                            in_frame = 1'b0;
                        end
                    end
                end
            end else if (in_frame) begin
                idle++;
                if (timeout_cycles != 16'd0 && idle == int'(timeout_cycles)) model_err(2'b11);
            end
            prev_done = rx_done;
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        checkOutput("out_valid", out_if.out_valid, (mq.size() != 0));
        checkOutput("out_data", out_if.out_data, (mq.size() != 0) ? mq[0][7:0] : 8'h00);
        checkOutput("out_last", out_if.out_last, (mq.size() != 0) ? mq[0][8] : 1'b0);
        checkOutput("frame_ok", frame_ok, exp_ok);
        checkOutput("frame_err", frame_err, exp_err);
        checkOutput("err_code", err_code, exp_code);
        checkOutput("frame_cnt", frame_cnt, exp_cnt);
    end

    always @(negedge clk) begin
        case (ready_mode)
            0: out_if.out_ready = 1'b0;
            1: out_if.out_ready = 1'b1;
            default: out_if.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic [8:0] pop_log[$];
    int ok_seen = 0;
    int err_seen = 0;
    always @(posedge clk) begin
        if (rst_n) begin
            if (out_if.out_valid && out_if.out_ready) pop_log.push_back({out_if.out_last, out_if.out_data});
            if (frame_ok) ok_seen++;
            if (frame_err) err_seen++;
        end
    end

    logic [7:0] tx_q[$];

    task automatic applyStimulus(input logic [7:0] b, input int hold, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    // hold/gap of 0 pick a random 1..4 per byte
    task automatic send_queue(input int hold, input int gap);
        foreach (tx_q[i]) begin
            applyStimulus(tx_q[i], (hold > 0) ? hold : $urandom_range(1, 4), (gap > 0) ? gap : $urandom_range(1, 4));
        end
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete, got hang, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int ok_base;
    int err_base;
    int err_cyc;
    bit found;
    int len_r;
    int cut;
    logic [7:0] sum_r;
    logic [7:0] b_r;
    logic [8:0] exp3[3];

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", out_if.out_valid, 1'b0);
        checkOutput("reset_cnt", frame_cnt, 8'h00);
        checkOutput("reset_code", err_code, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        // Good frame, each byte held for 5 cycles
        pop_log.delete();
        ok_base = ok_seen;
        tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_queue(5, 2);
        repeat (6) @(negedge clk);
        exp3 = '{9'h011, 9'h022, 9'h133};
        checkOutput("good_pops", 16'(pop_log.size()), 16'd3);
        for (int i = 0; i < 3; i++) checkOutput("good_byte", pop_log[i], exp3[i]);
        checkOutput("good_ok_pulses", 16'(ok_seen - ok_base), 16'd1);
        checkOutput("good_cnt", frame_cnt, 8'd1);

        // Checksum error, payload still delivered
        pop_log.delete();
        err_base = err_seen;
        tx_q = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        send_queue(1, 1);
        repeat (4) @(negedge clk);
        checkOutput("csum_err_pulses", 16'(err_seen - err_base), 16'd1);
        checkOutput("csum_code", err_code, 2'b10);
        checkOutput("csum_pops", 16'(pop_log.size()), 16'd2);
        checkOutput("csum_byte0", pop_log[0], 9'h010);
        checkOutput("csum_byte1", pop_log[1], 9'h120);
        checkOutput("csum_cnt", frame_cnt, 8'd1);

        // Zero length
        pop_log.delete();
        tx_q = {8'hA5, 8'h00};
        send_queue(1, 1);
        repeat (3) @(negedge clk);
        checkOutput("zlen_code", err_code, 2'b01);
        checkOutput("zlen_pops", 16'(pop_log.size()), 16'd0);

        // Inter-byte timeout of 100 cycles
        timeout_cycles = 16'd100;
        tx_q = {8'hA5, 8'h04, 8'h01};
        send_queue(1, 1);
        found = 1'b0;
        err_cyc = 0;
        for (int i = 0; i < 150 && !found; i++) begin
            @(negedge clk);
            if (frame_err) begin
                found = 1'b1;
                err_cyc = cyc;
            end
        end
        checkOutput("to_seen", found, 1'b1);
        checkOutput("to_delay", 16'(err_cyc - last_ev_cyc), 16'd100);
        checkOutput("to_code", err_code, 2'b11);
        tx_q = {8'hA5, 8'h01, 8'h07, 8'h08};
        send_queue(1, 1);
        repeat (3) @(negedge clk);
        checkOutput("after_to_cnt", frame_cnt, 8'd2);

        // Overflow: consumer stalled, 20-byte payload with correct checksum
        timeout_cycles = 16'd0;
        ready_mode = 0;
        repeat (2) @(negedge clk);
        pop_log.delete();
        tx_q = {8'hA5, 8'd20};
        for (int i = 1; i <= 20; i++) tx_q.push_back(8'(i));
        tx_q.push_back(8'hE6);
        send_queue(1, 1);
        repeat (3) @(negedge clk);
        checkOutput("ovf_code", err_code, 2'b00);
        checkOutput("ovf_cnt", frame_cnt, 8'd2);
        ready_mode = 1;
        repeat (30) @(negedge clk);
        checkOutput("ovf_stored", 16'(pop_log.size()), 16'd16);
        checkOutput("ovf_first", pop_log[0], 9'h001);
        checkOutput("ovf_last_entry", pop_log[15], 9'h010);

        // Reset mid-payload with rx_done held high across release
        ready_mode = 0;
        tx_q = {8'hA5, 8'h05, 8'h01, 8'h02};
        send_queue(1, 1);
        rx_data = 8'hA5;
        rx_done = 1'b1;
        err_base = err_seen;
        ok_base = ok_seen;
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_valid", out_if.out_valid, 1'b0);
        checkOutput("rst_data", out_if.out_data, 8'h00);
        checkOutput("rst_cnt", frame_cnt, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rx_done = 1'b0;
        ready_mode = 1;
        repeat (2) @(negedge clk);
        tx_q = {8'hA5, 8'h01, 8'h05, 8'h06};
        send_queue(1, 1);
        repeat (3) @(negedge clk);
        checkOutput("rst_no_err", 16'(err_seen - err_base), 16'd0);
        checkOutput("rst_one_ok", 16'(ok_seen - ok_base), 16'd1);
        checkOutput("rst_then_cnt", frame_cnt, 8'd1);

        // Randomized frames, random consumer, occasional truncation into timeout
        timeout_cycles = 16'd60;
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) begin
                b_r = 8'($urandom);
                if (b_r == 8'hA5) b_r = 8'h5A;
                applyStimulus(b_r, $urandom_range(1, 4), $urandom_range(1, 4));
            end
            len_r = (f % 10 == 3) ? 0 : $urandom_range(1, 24);
            tx_q = {8'hA5, 8'(len_r)};
            sum_r = 8'(len_r);
            for (int i = 0; i < len_r; i++) begin
                b_r = 8'($urandom);
                tx_q.push_back(b_r);
                sum_r = sum_r + b_r;
            end
            if (len_r != 0) tx_q.push_back(($urandom_range(0, 4) == 0) ? (sum_r ^ 8'h01) : sum_r);
            if (len_r != 0 && $urandom_range(0, 7) == 0) begin
                cut = $urandom_range(2, tx_q.size() - 1);
                while (tx_q.size() > cut) void'(tx_q.pop_back());
                send_queue(0, 0);
                repeat (70) @(negedge clk);
            end else begin
                send_queue(0, 0);
            end
        end
        ready_mode = 1;
        repeat (60) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
